// File: rtl/v4_peak_capture.sv
// rtl/v4_peak_capture.sv - threshold-triggered peak capture with dead time and pile-up detection
//
// Purpose:
//   Watches a shaped filter stream. A strict crossing above threshold (while
//   enabled) starts an event. The crossing timestamp is latched, and the largest
//   sample over the following PEAK_WIN cycles is tracked. The result is presented
//   as a valid/ready record. After the record is taken, the block sits in a dead
//   time. It re-arms only once the signal has fallen back to or below threshold.
//
// Optional feature:
//   V4_PILEUP_REJECT_EN - when defined, a second crossing inside the search
//   window (after a dip below threshold-HYST) discards the event and is counted
//   in pileup_cnt. When undefined, such crossings are ignored and pileup_cnt is 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   filter_data  unsigned filter sample, one per cycle
//   threshold    unsigned trigger level
//   enable       arming permission (gates IDLE->SEARCH only)
//   evt_valid    event record available (HOLD only)
//   evt_ready    consumer accepts record
//   evt_amp      peak amplitude of the event
//   evt_time     timestamp of the threshold crossing
//   pileup_cnt   saturating count of rejected pile-ups
//   busy         high whenever the FSM is not idle

`ifndef SIZE_FILTER_DATA
`define SIZE_FILTER_DATA 16
`endif

module v4_peak_capture #(
  parameter int DATA_W    = `SIZE_FILTER_DATA,
  parameter int TS_W      = 32,
  parameter int PEAK_WIN  = 16,
  parameter int DEAD_TIME = 32,
  parameter int HYST      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] filter_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic              enable,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]   evt_time,
  output logic [15:0]       pileup_cnt,
  output logic              busy
);

  localparam int WIN_W  = $clog2(PEAK_WIN + 1);
  localparam int DEAD_W = $clog2(DEAD_TIME + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(PEAK_WIN - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TIME - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, HOLD, DEAD} state_t;

  state_t            state;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] max_val;
  logic [TS_W-1:0]   cross_ts;
  logic [WIN_W-1:0]  win_cnt;
  logic [DEAD_W-1:0] dead_cnt;

  logic              above;
  logic [DATA_W-1:0] max_next;

  assign above    = filter_data > threshold;
  // Strict compare keeps the earliest sample on ties.
  assign max_next = (filter_data > max_val) ? filter_data : max_val;
  assign busy     = (state != IDLE);

`ifdef V4_PILEUP_REJECT_EN
  localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);
  logic [DATA_W-1:0] rearm_lvl;
  logic              dipped;
  logic              pileup;

  // Re-arm level saturates at zero, so a tiny threshold can never register a dip.
  assign rearm_lvl = (threshold > HYST_V) ? (threshold - HYST_V) : '0;
  assign pileup    = dipped && above;
`else
  assign pileup_cnt = 16'h0000;
`endif

  // Free-running timestamp; wraps naturally at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      max_val   <= '0;
      cross_ts  <= '0;
      win_cnt   <= '0;
      dead_cnt  <= '0;
      evt_valid <= 1'b0;
      evt_amp   <= '0;
      evt_time  <= '0;
`ifdef V4_PILEUP_REJECT_EN
      dipped     <= 1'b0;
      pileup_cnt <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable && above) begin
            max_val  <= filter_data;
            cross_ts <= ts;
            win_cnt  <= '0;
            state    <= SEARCH;
`ifdef V4_PILEUP_REJECT_EN
            dipped   <= 1'b0;
`endif
          end
        end

        SEARCH: begin
`ifdef V4_PILEUP_REJECT_EN
          if (pileup) begin
            state    <= DEAD;
            dead_cnt <= '0;
            if (pileup_cnt != 16'hFFFF) pileup_cnt <= pileup_cnt + 16'h0001;
          end else begin
            if (filter_data < rearm_lvl) dipped <= 1'b1;
`else
          begin
`endif
            max_val <= max_next;
            // The last window cycle's sample still competes for the peak.
            if (win_cnt == WIN_LAST) begin
              state     <= HOLD;
              evt_valid <= 1'b1;
              evt_amp   <= max_next;
              evt_time  <= cross_ts;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
        end

        HOLD: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            dead_cnt  <= '0;
            state     <= DEAD;
          end
        end

        DEAD: begin
          // Counter saturates at its last value; leaving waits for the level to fall.
          if (dead_cnt != DEAD_LAST) dead_cnt <= dead_cnt + 1'b1;
          else if (!above)           state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v4_peak_capture.sv
// tb/tb_v4_peak_capture.sv - directed self-checking bench for v4_peak_capture

module tb_v4_peak_capture;

  localparam int DW = 16;
  localparam int TW = 8;
  localparam int PW = 16;
  localparam int DT = 32;
  localparam int HY = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] filter_data = '0;
  logic [DW-1:0] threshold = 16'd100;
  logic          enable = 1'b0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [DW-1:0] evt_amp;
  logic [TW-1:0] evt_time;
  logic [15:0]   pileup_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int rec_cnt = 0;
  logic [TW-1:0] tb_ts;

  v4_peak_capture #(
    .DATA_W(DW), .TS_W(TW), .PEAK_WIN(PW), .DEAD_TIME(DT), .HYST(HY)
  ) dut (
    .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
    .enable(enable), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_amp(evt_amp), .evt_time(evt_time), .pileup_cnt(pileup_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1'b1;
  end

  // Handshake monitor: counts delivered records.
  always @(posedge clk) begin
    if (!reset && evt_valid && evt_ready) rec_cnt <= rec_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (evt_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int exp_rec;
    logic [TW-1:0] t0;
    logic ok;

    exp_rec = 0;

    // Reset state
    #12;
    check("rst_valid", evt_valid, 0);
    check("rst_amp", evt_amp, 0);
    check("rst_time", evt_time, 0);
    check("rst_pileup", pileup_cnt, 0);
    check("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    enable = 1'b1;
    threshold = 16'd100;
    evt_ready = 1'b1;
    repeat (3) tick();

    // Basic pulse, peak on third search cycle, ready held high
    filter_data = 16'd120; t0 = tb_ts; tick();
    check("t1_busy", busy, 1);
    filter_data = 16'd130; tick();
    filter_data = 16'd140; tick();
    filter_data = 16'd150; tick();
    filter_data = 16'd140; tick();
    filter_data = 16'd0;
    wait_valid(30, n);
    check("t1_valid", evt_valid, 1);
    check("t1_latency", 5 + n, PW + 1);
    check("t1_amp", evt_amp, 150);
    check("t1_time", evt_time, t0);
    tick();
    exp_rec++;
    check("t1_one_cycle", evt_valid, 0);
    check("t1_rec", rec_cnt, exp_rec);

    // Second pulse in dead time, level held past dead-time end
    repeat (9) tick();
    filter_data = 16'd200;
    repeat (40) tick();
    check("dead_hold_busy", busy, 1);
    check("dead_no_valid", evt_valid, 0);
    filter_data = 16'd50; tick();
    check("dead_exit", busy, 0);
    repeat (3) tick();
    check("dead_no_rec", rec_cnt, exp_rec);

    // Back-pressure: ready low for 10 HOLD cycles
    evt_ready = 1'b0;
    filter_data = 16'd120; t0 = tb_ts; tick();
    filter_data = 16'd150; tick();
    filter_data = 16'd0;
    wait_valid(30, n);
    check("t2_valid", evt_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("t2_stable_valid", evt_valid, 1);
      check("t2_stable_amp", evt_amp, 150);
      check("t2_stable_time", evt_time, t0);
      tick();
    end
    check("t2_valid_11th", evt_valid, 1);
    evt_ready = 1'b1;
    tick();
    exp_rec++;
    check("t2_dropped", evt_valid, 0);
    check("t2_rec", rec_cnt, exp_rec);
    repeat (40) tick();
    check("t2_idle", busy, 0);
    check("t2_no_extra", rec_cnt, exp_rec);

    // Equality does not trigger, one LSB above does
    filter_data = 16'd100;
    ok = 1'b1;
    repeat (30) begin
      tick();
      if (busy !== 1'b0) ok = 1'b0;
    end
    check("eq_no_trigger", ok, 1);
    filter_data = 16'd101; t0 = tb_ts; tick();
    check("eq101_busy", busy, 1);
    filter_data = 16'd0;
    wait_valid(30, n);
    check("eq101_valid", evt_valid, 1);
    check("eq101_amp", evt_amp, 101);
    check("eq101_time", evt_time, t0);
    tick();
    exp_rec++;
    repeat (40) tick();
    check("eq101_idle", busy, 0);
    check("eq101_rec", rec_cnt, exp_rec);

    // Enable low blocks arming
    enable = 1'b0;
    filter_data = 16'd200;
    repeat (5) tick();
    check("en_gate", busy, 0);
    filter_data = 16'd0;
    enable = 1'b1;
    tick();

    // Pile-up: 150, dip to 90 (< 96), rise to 120
    filter_data = 16'd150; tick();
    filter_data = 16'd90;  tick();
    filter_data = 16'd120; tick();
    filter_data = 16'd0;
`ifdef V4_PILEUP_REJECT_EN
    check("pu_busy_dead", busy, 1);
    check("pu_cnt", pileup_cnt, 1);
    repeat (45) tick();
    check("pu_no_rec", rec_cnt, exp_rec);
    check("pu_idle", busy, 0);
`else
    wait_valid(30, n);
    check("pu_valid", evt_valid, 1);
    check("pu_amp", evt_amp, 150);
    check("pu_cnt", pileup_cnt, 0);
    tick();
    exp_rec++;
    repeat (40) tick();
    check("pu_rec", rec_cnt, exp_rec);
`endif

    // Reset during SEARCH
    filter_data = 16'd150; tick();
    filter_data = 16'd160; tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("rs_search_busy", busy, 0);
    check("rs_search_valid", evt_valid, 0);
    check("rs_search_amp", evt_amp, 0);
    check("rs_search_time", evt_time, 0);
    tick();
    reset = 1'b0;

    // Trigger on first edge after release, then reset during HOLD
    evt_ready = 1'b0;
    filter_data = 16'd150; t0 = tb_ts; tick();
    check("rs_first_trig", busy, 1);
    filter_data = 16'd0;
    wait_valid(30, n);
    check("rs_hold_valid", evt_valid, 1);
    check("rs_hold_time", evt_time, t0);
    #2 reset = 1'b1;
    #1;
    check("rs_hold_valid0", evt_valid, 0);
    check("rs_hold_amp0", evt_amp, 0);
    check("rs_hold_time0", evt_time, 0);
    check("rs_hold_busy0", busy, 0);
    check("rs_hold_pu0", pileup_cnt, 0);
    tick();
    reset = 1'b0;
    evt_ready = 1'b1;
    tick();
    check("rs_no_rec", rec_cnt, exp_rec);

    // Timestamp wrap: trigger at ts=2 after the 8-bit counter wraps
    n = 0;
    while (tb_ts !== 8'hFF && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    filter_data = 16'd130; tick();
    enable = 1'b0;
    filter_data = 16'd0;
    wait_valid(30, n);
    check("wrap_valid", evt_valid, 1);
    check("wrap_time", evt_time, 8'h02);
    check("wrap_amp", evt_amp, 130);
    tick();
    exp_rec++;
    check("wrap_rec", rec_cnt, exp_rec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
